param_prio_arbiter: RTL and testbench

Parametrised N-requester arbiter replacing the fixed 5-agent priority arbiter. Two runtime-selectable schemes: fixed priority (index 0 highest) and round robin. Grants are registered and one-hot, with a bounded hold time so a persistent requester cannot starve others. It sits between bus masters and a shared slave or resource.

---
 rtl/param_prio_arbiter.sv | 115 +++++++++++
 tb/tb_param_prio_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/param_prio_arbiter.sv
// N-requester arbiter: fixed-priority or round-robin, registered one-hot grant, bounded hold.
// Optional ARB_LOCK_EN adds a lock input that pins the current owner.
module param_prio_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       mode_rr,
`ifdef ARB_LOCK_EN
  input  logic                       lock,
`endif
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int HC_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_valid;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [HC_W-1:0]     r_hold;

  logic [NUM_REQ-1:0]  w_cand;
  logic [NUM_REQ-1:0]  w_rot;
  logic                w_any;
  logic                w_own;
  logic                w_lock;
  logic                w_expire;
  logic                w_do_grant;
  logic                w_go_idle;
  logic                w_hold_inc;
  logic [ID_W-1:0]     w_rr_win;
  logic [ID_W-1:0]     w_win;
  logic [ID_W-1:0]     w_next_ptr;

  function automatic logic [ID_W-1:0] f_lowest(
    input logic [NUM_REQ-1:0] v
  );
    f_lowest = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (v[k]) f_lowest = ID_W'(k);
  endfunction

  function automatic logic [ID_W-1:0] f_wrap(input int s);
    f_wrap = (s >= NUM_REQ) ? ID_W'(s - NUM_REQ) : ID_W'(s);
  endfunction

`ifdef ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // The owner is never a candidate, so release and expiry share one pick.
  assign w_cand   = req & ~r_gnt;
  assign w_any    = |w_cand;
  assign w_own    = |(req & r_gnt);
  assign w_rot    = NUM_REQ'({w_cand, w_cand} >> r_rr_ptr);
  assign w_rr_win = f_wrap(int'(r_rr_ptr) + int'(f_lowest(w_rot)));
  assign w_win    = mode_rr ? w_rr_win : f_lowest(w_cand);
  assign w_next_ptr = f_wrap(int'(w_win) + 1);

  assign w_expire   = (MAX_HOLD != 0) && (r_hold == HC_MAX)
                      && w_any && !w_lock;
  assign w_do_grant = w_any && (!w_own || w_expire);
  assign w_go_idle  = (r_state == OWNED) && !w_own && !w_any;
  assign w_hold_inc = (r_state == OWNED) && w_own && !w_expire
                      && !w_lock && (MAX_HOLD != 0)
                      && (r_hold != HC_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_hold   <= '0;
    end else begin
      unique case (1'b1)
        w_do_grant: begin
          r_state  <= OWNED;
          r_gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          r_valid  <= 1'b1;
          r_id     <= w_win;
          r_rr_ptr <= w_next_ptr;
          r_hold   <= HC_W'(1);
        end
        w_go_idle: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_id    <= '0;
          r_hold  <= '0;
        end
        w_hold_inc: r_hold <= r_hold + HC_W'(1);
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_id;

endmodule

// File: tb/tb_param_prio_arbiter.sv
// Directed bench for param_prio_arbiter (NUM_REQ=5, MAX_HOLD=4 and 1).
// Lock scenario is exercised only when ARB_LOCK_EN is defined.
module tb_param_prio_arbiter;

  logic       clock;
  logic       reset_n;
  logic [4:0] req;
  logic       mode_rr;
  logic [4:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic [4:0] req1;
  logic       mode_rr1;
  logic [4:0] gnt1;
  logic       gnt_valid1;
  logic [2:0] gnt_id1;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  param_prio_arbiter #(.NUM_REQ(5), .MAX_HOLD(4)) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .mode_rr   (mode_rr),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  param_prio_arbiter #(.NUM_REQ(5), .MAX_HOLD(1)) u_dut1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req1),
    .mode_rr   (mode_rr1),
`ifdef ARB_LOCK_EN
    .lock      (1'b0),
`endif
    .gnt       (gnt1),
    .gnt_valid (gnt_valid1),
    .gnt_id    (gnt_id1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] eg,
                         input logic ev, input logic [2:0] ei);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".valid"}, 32'(gnt_valid), 32'(ev));
    chk({tag, ".id"}, 32'(gnt_id), 32'(ei));
  endtask

  logic [2:0] rr_seq [7];
  logic [4:0] exp_g;

  initial begin
    rr_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    reset_n  = 1'b0;
    req      = '0;
    mode_rr  = 1'b0;
    req1     = '0;
    mode_rr1 = 1'b0;
`ifdef ARB_LOCK_EN
    lock     = 1'b0;
`endif
    #2;
    chk_out("reset", 5'b00000, 1'b0, 3'd0);
    chk("reset.dut1", 32'(gnt1), 32'd0);
    step();
    reset_n = 1'b1;

    // fixed priority from idle
    req = 5'b11010;
    step();
    chk_out("fixed_first", 5'b00010, 1'b1, 3'd1);
    req = 5'b00000;
    step();
    chk_out("release_idle", 5'b00000, 1'b0, 3'd0);

    // hold expiry alternation between agents 0 and 1
    req = 5'b00011;
    for (int r = 0; r < 3; r++) begin
      exp_g = (r % 2 == 0) ? 5'b00001 : 5'b00010;
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("alt_r%0d_c%0d", r, c), 32'(gnt), 32'(exp_g));
      end
    end
    req = 5'b00000;
    step();
    chk("alt_idle", 32'(gnt_valid), 32'd0);

    // release handover without idle bubble
    req = 5'b01100;
    step();
    chk_out("owner2", 5'b00100, 1'b1, 3'd2);
    req = 5'b01000;
    step();
    chk_out("handover", 5'b01000, 1'b1, 3'd3);
    req = 5'b00000;
    step();
    chk_out("handover_idle", 5'b00000, 1'b0, 3'd0);

    // round robin, one grant per cycle with MAX_HOLD=1
    mode_rr1 = 1'b1;
    req1 = 5'b11111;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("rr1_id%0d", i), 32'(gnt_id1), 32'(rr_seq[i]));
      chk($sformatf("rr1_valid%0d", i), 32'(gnt_valid1), 32'd1);
    end
    req1 = 5'b00000;

    // rr pointer carried over from last fixed grant (agent 3)
    mode_rr = 1'b1;
    req = 5'b11111;
    step();
    chk_out("rr_from_ptr", 5'b10000, 1'b1, 3'd4);
    step();
    chk("rr_hold", 32'(gnt_id), 32'd4);

    // asynchronous reset mid-grant
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_rst", 5'b00000, 1'b0, 3'd0);
    step();
    reset_n = 1'b1;
    step();
    chk_out("rr_after_rst", 5'b00001, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rr_keep%0d", i), 32'(gnt_id), 32'd0);
    end
    step();
    chk_out("rr_expire", 5'b00010, 1'b1, 3'd1);
    req = 5'b00000;
    step();
    chk("rr_idle", 32'(gnt), 32'd0);

`ifdef ARB_LOCK_EN
    mode_rr = 1'b0;
    req = 5'b00001;
    for (int i = 0; i < 4; i++) step();
    chk("lock_pre", 32'(gnt), 32'b00001);
    req = 5'b00011;
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("lock_hold%0d", i), 32'(gnt), 32'b00001);
    end
    lock = 1'b0;
    step();
    chk_out("lock_drop", 5'b00010, 1'b1, 3'd1);
    req = 5'b00000;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
